// File: rtl/audio_rate_buffer_pkg.sv
// Shared audio types: decoder coding header, stereo frame layout and native playback rates.
package audio_rate_buffer_pkg;

  typedef enum logic {kMono, kStereo} chan_e;
  typedef enum logic {k37Khz, k18Khz} rate_e;
  typedef enum logic [1:0] {k4Bps, k8Bps, k16Bps} bps_e;

  typedef struct packed {
    chan_e chan;
    rate_e rate;
    bps_e  bps;
  } header_coding_s;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } stereo_frame_s;

  localparam logic [31:0] RATE_37K8 = 32'd37800;
  localparam logic [31:0] RATE_18K9 = 32'd18900;
  localparam logic [31:0] RATE_44K1 = 32'd44100;

  function automatic logic [31:0] rate_for(header_coding_s c);
    if (c.bps == k16Bps) return RATE_44K1;
    if (c.rate == k18Khz) return RATE_18K9;
    return RATE_37K8;
  endfunction

endpackage

// File: rtl/audio_rate_buffer_sync_frame_fifo.sv
// Frame FIFO: block-RAM storage with registered read, plus an output register giving
// first-word-fall-through; a push into an otherwise empty FIFO bypasses the RAM.
module sync_frame_fifo #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [31:0]              din,
  input  logic                     pop,
  output logic [31:0]              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   mem_q, byp_q;
  logic          use_mem, out_valid;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   mem_count, level_q;
  logic          do_push, do_pop, refill, from_mem, bypass, mem_wr;

  assign do_push  = push && !full;
  assign do_pop   = pop && out_valid;
  assign refill   = do_pop || !out_valid;
  assign from_mem = refill && (|mem_count);
  assign bypass   = refill && !(|mem_count) && do_push;
  assign mem_wr   = do_push && !bypass;

  assign dout  = use_mem ? mem_q : byp_q;
  assign full  = (level_q == LW'(DEPTH));
  assign empty = !(|level_q);
  assign level = level_q;

  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr] <= din;
    if (from_mem) mem_q <= mem[rd_ptr];
  end

  // The output register holds the head frame; the RAM holds everything behind it.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      level_q   <= '0;
      out_valid <= 1'b0;
      use_mem   <= 1'b0;
      byp_q     <= '0;
    end else begin
      if (mem_wr) wr_ptr <= wr_ptr + 1'b1;
      if (from_mem) rd_ptr <= rd_ptr + 1'b1;
      mem_count <= mem_count + LW'(mem_wr) - LW'(from_mem);
      level_q   <= level_q + LW'(do_push) - LW'(do_pop);
      if (refill) begin
        out_valid <= from_mem || bypass;
        use_mem   <= from_mem;
      end
      if (bypass) byp_q <= din;
    end
  end

endmodule

// File: rtl/audio_rate_buffer.sv
// Pairs decoded samples into stereo frames, buffers them and replays them at the
// latched native rate using a fractional phase accumulator.
//   state     | meaning
//   IDLE      | waiting for in_write with room for the sample
//   ACCEPT    | strobe the sample, stage and/or push its frame
//   WAIT_DROP | wait for the source to drop in_write
module audio_rate_buffer
  import audio_rate_buffer_pkg::*;
#(
  parameter int CLK_HZ     = 30000000,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   in_sample,
  input  logic                          in_write,
  output logic                          in_strobe,
  input  logic                          in_channel,
  input  header_coding_s                coding,
  input  logic                          flush,
  output logic [15:0]                   out_left,
  output logic [15:0]                   out_right,
  output logic                          out_tick,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);
  localparam logic [31:0] CLK_HZ_U = 32'(CLK_HZ);

  typedef enum logic [1:0] {IDLE, ACCEPT, WAIT_DROP} in_state_e;
  in_state_e state, state_next;

  logic [15:0]   staging;
  logic          staging_valid;
  logic          stereo, needs_push;
  logic          push, pop, fifo_full, fifo_empty;
  stereo_frame_s push_frame, pop_frame;
  logic [31:0]   fifo_dout;
  logic [31:0]   rate_latched, acc, acc_sum;
  logic          tick;

  assign stereo     = (coding.chan == kStereo);
  assign needs_push = !stereo || in_channel || staging_valid;
  assign acc_sum    = acc + rate_latched;
  assign tick       = (acc_sum >= CLK_HZ_U);
  assign pop        = tick && !fifo_empty && !flush;
  assign pop_frame  = fifo_dout;

  always_comb begin
    state_next = state;
    in_strobe  = 1'b0;
    push       = 1'b0;
    push_frame = {in_sample, in_sample};
    if (stereo && in_channel && staging_valid) push_frame = {staging, in_sample};
    else if (stereo && !in_channel)            push_frame = {staging, staging};
    case (state)
      IDLE:      if (in_write && (!needs_push || !fifo_full)) state_next = ACCEPT;
      ACCEPT: begin
        if (needs_push && fifo_full) begin
          state_next = IDLE;
        end else begin
          in_strobe  = 1'b1;
          push       = needs_push;
          state_next = WAIT_DROP;
        end
      end
      WAIT_DROP: if (!in_write) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (flush || reset) begin
      state_next = IDLE;
      in_strobe  = 1'b0;
      push       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      staging       <= '0;
      staging_valid <= 1'b0;
      rate_latched  <= RATE_44K1;
      acc           <= '0;
      out_left      <= '0;
      out_right     <= '0;
      out_tick      <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      state    <= state_next;
      acc      <= tick ? acc_sum - CLK_HZ_U : acc_sum;
      out_tick <= tick;
      underrun <= tick && (fifo_empty || flush);
      if (pop) begin
        out_left  <= pop_frame.left;
        out_right <= pop_frame.right;
      end
      // Rate only follows the coding when the buffer restarts from empty.
      if (push && fifo_empty) rate_latched <= rate_for(coding);
      if (flush) begin
        staging_valid <= 1'b0;
      end else if (in_strobe && stereo) begin
        if (!in_channel) begin
          staging       <= in_sample;
          staging_valid <= 1'b1;
        end else begin
          staging_valid <= 1'b0;
        end
      end
    end
  end

  sync_frame_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .din   (push_frame),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fill_level)
  );

endmodule

// File: tb/tb_audio_rate_buffer.sv
// Bench for audio_rate_buffer: queue-based reference model checked every cycle plus
// directed scenarios with literal expectations.
module tb_audio_rate_buffer;
  import audio_rate_buffer_pkg::*;

  localparam int CLK_HZ = 378000;
  localparam int DEPTH  = 16;

  logic clk, reset, in_write, in_strobe, in_channel, flush;
  logic [15:0] in_sample, out_left, out_right;
  logic out_tick, underrun;
  logic [$clog2(DEPTH):0] fill_level;
  header_coding_s coding;

  audio_rate_buffer #(.CLK_HZ(CLK_HZ), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_sample(in_sample), .in_write(in_write),
    .in_strobe(in_strobe), .in_channel(in_channel), .coding(coding), .flush(flush),
    .out_left(out_left), .out_right(out_right), .out_tick(out_tick),
    .underrun(underrun), .fill_level(fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model state
  logic [31:0] q[$];
  int unsigned m_acc, m_rate;
  logic [15:0] m_stage;
  bit m_stage_v, prev_strobe, model_valid;
  logic [15:0] e_left, e_right;
  bit e_tick, e_under;
  int e_level;

  // observations of the DUT
  int cyc = 0, strobe_count = 0, tick_count = 0, under_count = 0;
  int last_tick = -1, tick_gap = 0;
  logic [31:0] seen[$];

  function automatic int unsigned rate_of(header_coding_s c);
    if (c.bps == k16Bps) return 44100;
    if (c.rate == k18Khz) return 18900;
    return 37800;
  endfunction

  always @(negedge clk) begin
    int start;
    bit pushed, t;
    logic [31:0] f;
    int unsigned sum;
    if (model_valid) begin
      n_cmp++;
      if (out_left !== e_left || out_right !== e_right || out_tick !== e_tick ||
          underrun !== e_under || fill_level !== e_level) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d: got L=%h R=%h tick=%b und=%b lvl=%0d required L=%h R=%h tick=%b und=%b lvl=%0d",
                 cyc, out_left, out_right, out_tick, underrun, fill_level,
                 e_left, e_right, e_tick, e_under, e_level);
      end
    end
    cyc++;
    if (out_tick) begin
      tick_count++;
      if (last_tick >= 0) tick_gap = cyc - last_tick;
      last_tick = cyc;
      if (underrun) under_count++;
      else seen.push_back({out_left, out_right});
    end
    // advance the model by the cycle now in progress
    if (reset) begin
      q.delete();
      m_acc = 0; m_rate = 44100; m_stage = '0; m_stage_v = 0;
      e_left = '0; e_right = '0; e_tick = 0; e_under = 0; prev_strobe = 0;
    end else begin
      start = q.size();
      pushed = 0;
      f = '0;
      if (in_strobe) begin
        strobe_count++;
        check("strobe_with_write", in_write, 1);
        check("strobe_not_back_to_back", prev_strobe, 0);
        check("strobe_not_in_flush", flush, 0);
        if (coding.chan != kStereo) begin
          f = {in_sample, in_sample}; pushed = 1;
        end else if (in_channel) begin
          f = m_stage_v ? {m_stage, in_sample} : {in_sample, in_sample};
          pushed = 1; m_stage_v = 0;
        end else begin
          if (m_stage_v) begin f = {m_stage, m_stage}; pushed = 1; end
          m_stage = in_sample; m_stage_v = 1;
        end
        if (pushed) begin
          check("strobe_has_space", start < DEPTH, 1);
          q.push_back(f);
        end
      end
      sum = m_acc + m_rate;
      t = (sum >= CLK_HZ);
      m_acc = t ? sum - CLK_HZ : sum;
      if (pushed && start == 0) m_rate = rate_of(coding);
      if (flush) begin q.delete(); m_stage_v = 0; end
      e_tick = t; e_under = 0;
      if (t) begin
        if (start > 0 && !flush) begin
          f = q.pop_front();
          e_left = f[31:16]; e_right = f[15:0];
        end else begin
          e_under = 1;
        end
      end
      prev_strobe = in_strobe;
    end
    e_level = q.size();
    model_valid = 1;
  end

  task automatic send(input logic ch, input logic [15:0] s, input bit chk_lat);
    int c0, n;
    c0 = strobe_count; n = 0;
    @(posedge clk); #1;
    in_sample = s; in_channel = ch; in_write = 1;
    while (strobe_count == c0 && n < 100) begin @(posedge clk); #1; n++; end
    in_write = 0;
    if (strobe_count == c0) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: no strobe for sample %h within 100 cycles", s);
    end else if (chk_lat) begin
      check("accept_latency", n - 1, 1);
    end
  endtask

  task automatic wait_seen(input int k, input int bound);
    int n = 0;
    while (seen.size() < k && n < bound) begin @(negedge clk); n++; end
    #1;
    check("frames_popped", seen.size() >= k, 1);
  endtask

  task automatic flush_pulse();
    @(posedge clk); #1 flush = 1;
    @(posedge clk); #1 flush = 0;
    @(negedge clk); #1;
    check("flush_level", fill_level, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0, c0;
    logic [31:0] exp_m[4];
    reset = 1; in_write = 0; in_sample = '0; in_channel = 0; flush = 0;
    coding = '{chan: kMono, rate: k37Khz, bps: k4Bps};
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk); #1;
    check("reset_fill_level", fill_level, 0);
    check("reset_out_left", out_left, 0);
    check("reset_out_tick", out_tick, 0);
    check("reset_strobe", in_strobe, 0);

    // mono 37.8 kHz
    seen.delete();
    exp_m = '{32'h01000100, 32'h02000200, 32'h03000300, 32'h04000400};
    for (int i = 0; i < 4; i++) send(0, exp_m[i][15:0], 1);
    wait_seen(4, 80);
    repeat (25) @(negedge clk); #1;
    for (int i = 0; i < 4; i++) check("mono_frame", seen[i], exp_m[i]);
    check("mono_tick_gap", tick_gap, 10);
    check("underrun_hold_left", out_left, 16'h0400);
    check("underrun_hold_right", out_right, 16'h0400);
    check("underrun_seen", under_count > 0, 1);
    check("underrun_level", fill_level, 0);

    // stereo 18.9 kHz
    coding = '{chan: kStereo, rate: k18Khz, bps: k4Bps};
    seen.delete();
    send(0, 16'h1111, 1); send(1, 16'h2222, 1);
    send(0, 16'h3333, 1); send(1, 16'h4444, 1);
    wait_seen(2, 80);
    repeat (45) @(negedge clk); #1;
    check("stereo_frame0", seen[0], 32'h11112222);
    check("stereo_frame1", seen[1], 32'h33334444);
    check("stereo_tick_gap", tick_gap, 20);

    // fill to full, then a pending write waits for one tick
    coding = '{chan: kMono, rate: k18Khz, bps: k4Bps};
    n = 0;
    while (fill_level != DEPTH && n < 60) begin send(0, 16'h5000 + 16'(n), 1); n++; end
    check("fill_reached_full", fill_level, DEPTH);
    t0 = tick_count; c0 = strobe_count;
    send(0, 16'h5EEE, 0);
    check("full_strobe_after_tick", tick_count > t0, 1);
    @(negedge clk); #1;
    check("full_single_strobe", strobe_count - c0, 1);
    check("full_level_after_refill", fill_level, DEPTH);

    // flush with frames queued and staging valid
    flush_pulse();
    coding = '{chan: kStereo, rate: k18Khz, bps: k4Bps};
    n = 0;
    while (fill_level < 10 && n < 40) begin
      send(0, 16'h6000 + 16'(n), 1); send(1, 16'h6100 + 16'(n), 1); n++;
    end
    send(0, 16'h7777, 1);
    check("flush_prefill", fill_level >= 10, 1);
    flush_pulse();
    seen.delete();
    send(1, 16'hABCD, 1);
    wait_seen(1, 60);
    check("flush_then_ch1_dup", seen[0], 32'hABCDABCD);

    // 16-bit coding rate, unaffected by coding change while non-empty
    n = 0;
    while (fill_level != 0 && n < 100) begin @(negedge clk); n++; end
    coding = '{chan: kStereo, rate: k37Khz, bps: k16Bps};
    send(1, 16'h0001, 1); send(1, 16'h0002, 1); send(1, 16'h0003, 1);
    coding = '{chan: kMono, rate: k18Khz, bps: k4Bps};
    check("rate_fifo_nonempty", fill_level > 0, 1);
    send(0, 16'h0004, 1);
    @(negedge clk); #1;
    t0 = tick_count;
    repeat (CLK_HZ / 10) @(negedge clk);
    #1;
    n = tick_count - t0;
    check("rate_44k1_ticks", (n >= 4409 && n <= 4411), 1);

    // reset mid-stream
    coding = '{chan: kMono, rate: k37Khz, bps: k4Bps};
    seen.delete();
    send(0, 16'h1234, 1);
    wait_seen(1, 60);
    check("pre_reset_left", out_left, 16'h1234);
    send(0, 16'h2345, 1);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk); #1;
    check("reset_mid_left", out_left, 0);
    check("reset_mid_right", out_right, 0);
    check("reset_mid_level", fill_level, 0);
    check("reset_mid_tick", out_tick, 0);
    check("reset_mid_underrun", underrun, 0);
    repeat (30) @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
